// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel switch/button debouncer.
// Each channel synchronises its raw input, qualifies it over STABLE
// consecutive ticks and then publishes a clean level plus one-cycle
// rise/fall pulses. Channels share nothing but the tick enable.
module debounce_bank #(
  parameter int                  CHANNELS    = 8,
  parameter int                  STABLE      = 127,
  parameter int                  CNT_W       = 7,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [CHANNELS-1:0] INIT        = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [CHANNELS-1:0] dirty,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_edge
);

  // Terminal count as a counter-width constant so comparisons stay width-matched.
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s;
    logic                   last_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   clean_r;
    logic                   rise_r;
    logic                   fall_r;

    assign s = sync_r[SYNC_STAGES-1];

    // Synchroniser chain: runs every clock, never gated by tick.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync_r <= {SYNC_STAGES{INIT[i]}};
      end else begin
        sync_r <= {sync_r[SYNC_STAGES-2:0], dirty[i]};
      end
    end

    // Qualification: any change restarts the count, a full count publishes the level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        last_r  <= INIT[i];
        cnt_r   <= '0;
        clean_r <= INIT[i];
        rise_r  <= 1'b0;
        fall_r  <= 1'b0;
      end else begin
        rise_r <= 1'b0;
        fall_r <= 1'b0;
        if (s != last_r) begin
          last_r <= s;
          cnt_r  <= '0;
        end else if (tick && (cnt_r == STABLE_C)) begin
          clean_r <= last_r;
          if (last_r != clean_r) begin
            rise_r <= last_r;
            fall_r <= ~last_r;
          end
        end else if (tick && (cnt_r < STABLE_C)) begin
          cnt_r <= cnt_r + CNT_ONE;
        end
      end
    end

    assign clean[i] = clean_r;
    assign rise[i]  = rise_r;
    assign fall[i]  = fall_r;
  end

  assign any_edge = |(rise | fall);

endmodule

// File: tb/tb_debounce_bank.sv
// Directed testbench for debounce_bank with CHANNELS=4, STABLE=7,
// SYNC_STAGES=2, INIT=0. Inputs change just after a falling edge and
// outputs are sampled on falling edges, so a change made at one falling
// edge becomes visible on the 11th following falling edge.
module tb_debounce_bank;

  localparam int CH = 4;

  logic          clk;
  logic          rst_n;
  logic          tick;
  logic [CH-1:0] dirty;
  logic [CH-1:0] clean;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          any_edge;

  int vectors;
  int miscompares;

  logic [12:0] obs_v;
  logic [12:0] exp_v;

  debounce_bank #(
    .CHANNELS   (CH),
    .STABLE     (7),
    .CNT_W      (3),
    .SYNC_STAGES(2),
    .INIT       (4'b0000)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .dirty   (dirty),
    .clean   (clean),
    .rise    (rise),
    .fall    (fall),
    .any_edge(any_edge)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick  = 1'b1;
    dirty = 4'hF;
    wait_neg(5);
    obs_v = {clean, rise, fall, any_edge};
    vectors++;
    if (obs_v !== 13'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got %h expected %h", obs_v, 13'h0);
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j <= 10)      exp_v = {4'h0, 4'h0, 4'h0, 1'b0};
      else if (j == 11) exp_v = {4'hF, 4'hF, 4'h0, 1'b1};
      else              exp_v = {4'hF, 4'h0, 4'h0, 1'b0};
      obs_v = {clean, rise, fall, any_edge};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL reset_release j=%0d: got %h expected %h", j, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_press();
    dirty = 4'h0;
    wait_neg(12);
    vectors++;
    if (clean !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL press_setup: got %h expected %h", clean, 4'h0);
    end
    dirty = 4'h1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j <= 10)      exp_v = {4'h0, 4'h0, 4'h0, 1'b0};
      else if (j == 11) exp_v = {4'h1, 4'h1, 4'h0, 1'b1};
      else              exp_v = {4'h1, 4'h0, 4'h0, 1'b0};
      obs_v = {clean, rise, fall, any_edge};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL press j=%0d: got %h expected %h", j, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_bounce();
    int rise_cnt;
    rise_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      dirty[1] = ~dirty[1];
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        if (rise[1] === 1'b1) rise_cnt++;
        obs_v = {clean, rise, fall, any_edge};
        exp_v = {4'h1, 4'h0, 4'h0, 1'b0};
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL bounce t=%0d c=%0d: got %h expected %h", t, c, obs_v, exp_v);
        end
      end
    end
    dirty[1] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (rise[1] === 1'b1) rise_cnt++;
      if (j <= 10)      exp_v = {4'h1, 4'h0, 4'h0, 1'b0};
      else if (j == 11) exp_v = {4'h3, 4'h2, 4'h0, 1'b1};
      else              exp_v = {4'h3, 4'h0, 4'h0, 1'b0};
      obs_v = {clean, rise, fall, any_edge};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL bounce_settle j=%0d: got %h expected %h", j, obs_v, exp_v);
      end
    end
    vectors++;
    if (rise_cnt !== 1) begin
      miscompares++;
      $display("[TB] FAIL bounce_rise_count: got %0d expected %0d", rise_cnt, 1);
    end
  endtask

  task automatic test_release();
    dirty = 4'b0111;
    wait_neg(12);
    vectors++;
    if (clean !== 4'b0111) begin
      miscompares++;
      $display("[TB] FAIL release_setup: got %h expected %h", clean, 4'b0111);
    end
    dirty[2] = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (j < 11)       exp_v = {4'b0111, 4'b0000, 4'b0000, 1'b0};
      else if (j == 11) exp_v = {4'b0011, 4'b0000, 4'b0100, 1'b1};
      else if (j == 12) exp_v = {4'b0011, 4'b0000, 4'b0000, 1'b0};
      else if (j == 13) exp_v = {4'b1011, 4'b1000, 4'b0000, 1'b1};
      else              exp_v = {4'b1011, 4'b0000, 4'b0000, 1'b0};
      obs_v = {clean, rise, fall, any_edge};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL release j=%0d: got %h expected %h", j, obs_v, exp_v);
      end
      if (j == 2) dirty[3] = 1'b1;
    end
  endtask

  task automatic test_prescale();
    dirty = 4'b1010;
    tick  = 1'b1;
    wait_neg(12);
    vectors++;
    if (clean !== 4'b1010) begin
      miscompares++;
      $display("[TB] FAIL prescale_setup: got %h expected %h", clean, 4'b1010);
    end
    for (int n = 0; n <= 60; n++) begin
      if (n > 0) begin
        @(negedge clk);
        obs_v = {clean, rise, fall, any_edge};
        exp_v = {4'b1010, 4'h0, 4'h0, 1'b0};
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL prescale_glitch n=%0d: got %h expected %h", n, obs_v, exp_v);
        end
      end
      tick = ((n % 4) == 0);
      if (n == 0)  dirty[0] = 1'b1;
      if (n == 20) dirty[0] = 1'b0;
    end
    for (int n = 0; n <= 34; n++) begin
      if (n > 0) begin
        @(negedge clk);
        if (n < 33)       exp_v = {4'b1010, 4'h0, 4'h0, 1'b0};
        else if (n == 33) exp_v = {4'b1011, 4'h1, 4'h0, 1'b1};
        else              exp_v = {4'b1011, 4'h0, 4'h0, 1'b0};
        obs_v = {clean, rise, fall, any_edge};
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL prescale_press n=%0d: got %h expected %h", n, obs_v, exp_v);
        end
      end
      tick = ((n % 4) == 0);
      if (n == 0) dirty[0] = 1'b1;
    end
    tick = 1'b1;
  endtask

  task automatic test_collision();
    logic [2:0] cnt_obs;
    for (int n = 0; n <= 14; n++) begin
      if (n > 0) begin
        @(negedge clk);
        obs_v = {clean, rise, fall, any_edge};
        exp_v = {4'b1011, 4'h0, 4'h0, 1'b0};
        vectors++;
        if (obs_v !== exp_v) begin
          miscompares++;
          $display("[TB] FAIL collision n=%0d: got %h expected %h", n, obs_v, exp_v);
        end
        cnt_obs = dut.g_chan[0].cnt_r;
        if (n == 10) begin
          vectors++;
          if (cnt_obs !== 3'd7) begin
            miscompares++;
            $display("[TB] FAIL collision_cnt_full: got %0d expected %0d", cnt_obs, 7);
          end
        end
        if (n == 11) begin
          vectors++;
          if (cnt_obs !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL collision_cnt_restart: got %0d expected %0d", cnt_obs, 0);
          end
        end
        if (n == 12) begin
          vectors++;
          if (cnt_obs !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL collision_cnt_next: got %0d expected %0d", cnt_obs, 1);
          end
        end
      end
      if (n == 0) dirty[0] = 1'b0;
      if (n == 8) dirty[0] = 1'b1;
    end
  endtask

  // Scenario sequence; each task leaves the bank in the state the next one expects.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    tick        = 1'b1;
    dirty       = 4'hF;
    $display("[TB] debounce_bank directed test start");
    test_reset();
    test_press();
    test_bounce();
    test_release();
    test_prescale();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
